// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter driving one shared WIDTH-bit valid/ready channel.
// Latency: grant registered one cycle after req rises; zero bubble cycles on hand-over between requesters.
// Backpressure: out_rdy=0 freezes the burst counter and holds the grant indefinitely; beats move only on out_valid & out_rdy.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   req[3:0]              per-port request, held high while the port has data
//   port0..port3          requester data, WIDTH bits each
//   out_rdy               downstream accepts a beat this cycle
//   gnt[3:0], sel[1:0]    registered one-hot grant and granted index
//   dOut, out_valid, beat combinational channel data, valid, and transfer strobe
//
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority (port0 highest, port3 lowest);
// HOLD_MAX preemption still applies, the preempted port is excluded from the re-arbitration.

module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] port0,
    input  logic [WIDTH-1:0] port1,
    input  logic [WIDTH-1:0] port2,
    input  logic [WIDTH-1:0] port3,
    input  logic             out_rdy,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dOut,
    output logic             out_valid,
    output logic             beat
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;

    logic       busy;
    logic [3:0] others;
    logic       rls;
    logic [1:0] ptr_nxt;

    // First requesting index scanning p, p+1, p+2, p+3 (mod 4).
    // Scanning downward lets the nearest index overwrite farther ones.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] res;
        logic [1:0] idx;
        res = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = idx;
        end
        return res;
    endfunction

    assign busy      = (state_q == ST_BUSY);
    assign out_valid = busy & req[sel_q];
    assign beat      = out_valid & out_rdy;
    assign gnt       = gnt_q;
    assign sel       = sel_q;

    // Pending requesters other than the current holder.
    assign others = req & ~gnt_q;

    // Release when the holder drops, or when its burst budget is spent and
    // someone else is waiting; a lone holder keeps the grant.
    assign rls = busy & (~req[sel_q] | (beat & (cnt_q == CNT_LAST) & (|others)));

`ifdef ARB_FIXED_PRIO_EN
    assign ptr_nxt = 2'd0;
`else
    assign ptr_nxt = sel_q + 2'd1;
`endif

    always_comb begin
        dOut = port0;
        case (sel_q)
            2'd0:    dOut = port0;
            2'd1:    dOut = port1;
            2'd2:    dOut = port2;
            default: dOut = port3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_BUSY;
                    sel_d   = pick(req, ptr_q);
                    gnt_d   = 4'b0001 << pick(req, ptr_q);
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                // Saturate so a lone holder keeps streaming past HOLD_MAX.
                if (beat && cnt_q != CNT_LAST) cnt_d = cnt_q + 8'd1;
                if (rls) begin
                    ptr_d = ptr_nxt;
                    cnt_d = 8'd0;
                    if (|others) begin
                        sel_d = pick(others, ptr_nxt);
                        gnt_d = 4'b0001 << pick(others, ptr_nxt);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam int HM = 2;
`else
    localparam int HM = 4;
`endif

    logic       CLK;
    logic       RST_N;
    logic [3:0] req;
    logic [7:0] port0, port1, port2, port3;
    logic       out_rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] dOut;
    logic       out_valid;
    logic       beat;

    mux4_rr_arbiter #(.WIDTH(8), .HOLD_MAX(HM)) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req),
        .port0(port0), .port1(port1), .port2(port2), .port3(port3),
        .out_rdy(out_rdy), .gnt(gnt), .sel(sel), .dOut(dOut),
        .out_valid(out_valid), .beat(beat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] s;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [7:0] pdat(input int p);
        case (p)
            0:       return 8'h10;
            1:       return 8'h21;
            2:       return 8'hA5;
            default: return 8'h43;
        endcase
    endfunction

    task automatic push(input int p, input int n);
        exp_t x;
        x.s = 2'(p);
        x.d = pdat(p);
        repeat (n) q.push_back(x);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every transferred beat must match the next expected entry.
    always @(negedge CLK) begin
        if (RST_N && beat) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: sel=%0d data=%0h with empty queue at %0t", sel, dOut, $time);
            end else begin
                e = q.pop_front();
                check("beat_sel", int'(sel), int'(e.s));
                check("beat_data", int'(dOut), int'(e.d));
                check("beat_gnt", int'(gnt), int'(4'b0001 << e.s));
            end
        end
    end

    initial begin
        RST_N   = 1'b0;
        req     = 4'b0000;
        out_rdy = 1'b0;
        port0   = pdat(0);
        port1   = pdat(1);
        port2   = pdat(2);
        port3   = pdat(3);
        #3;
        check("rst_gnt", int'(gnt), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_dout", int'(dOut), 8'h10);
        step(2);
        RST_N = 1'b1;
        step();

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority with HOLD_MAX=2: port0 and port3 alternate in pairs.
        req = 4'b1001; out_rdy = 1'b1;
        step();
        check("fp_first_gnt", int'(gnt), 4'b0001);
        push(0, 2); push(3, 2); push(0, 2); push(3, 2);
        step(8);
        req = 4'b0000;
        step(2);
        check("fp_idle_gnt", int'(gnt), 0);
`else
        // Single requester, held past HOLD_MAX, then reset mid-burst.
        req = 4'b0100; out_rdy = 1'b1;
        step();
        check("single_gnt", int'(gnt), 4'b0100);
        check("single_sel", int'(sel), 2);
        check("single_valid", int'(out_valid), 1);
        push(2, 6);
        step(6);
        RST_N = 1'b0;
        #1;
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_sel", int'(sel), 0);
        check("midrst_dout", int'(dOut), 8'h10);
        req = 4'b0000;
        step();
        RST_N = 1'b1;
        step();

        // Full contention: 0,1,2,3,0 with 4 beats each, no bubbles.
        req = 4'b1111;
        step();
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
        step(20);
        req = 4'b0000;
        step(2);
        check("rr_idle_gnt", int'(gnt), 0);

        // Backpressure: grant held for 20 stalled cycles, then 4 beats and hand-over.
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        req = 4'b0010; out_rdy = 1'b0;
        step();
        check("bp_gnt", int'(gnt), 4'b0010);
        req = 4'b1111;
        step(20);
        check("bp_hold_gnt", int'(gnt), 4'b0010);
        push(1, 4);
        out_rdy = 1'b1;
        step(4);
        check("bp_next_gnt", int'(gnt), 4'b0100);
        out_rdy = 1'b0; req = 4'b0000;
        step(2);
        check("bp_idle_gnt", int'(gnt), 0);

        // Drop: holder 1 drops after one beat, port3 takes over, then idle.
        out_rdy = 1'b1; req = 4'b0010;
        step();
        check("drop_gnt", int'(gnt), 4'b0010);
        push(1, 1);
        req = 4'b1010;
        step();
        req = 4'b1000;
        step();
        check("drop_new_gnt", int'(gnt), 4'b1000);
        check("drop_new_sel", int'(sel), 3);
        push(3, 2);
        step(2);
        req = 4'b0000;
        step(2);
        check("drop_idle_gnt", int'(gnt), 0);

        // Saturated lone holder is preempted after its next beat once another requests.
        req = 4'b0001;
        step();
        check("sat_gnt", int'(gnt), 4'b0001);
        push(0, 6);
        step(6);
        req = 4'b0011;
        push(0, 1);
        step();
        check("sat_preempt_gnt", int'(gnt), 4'b0010);
        push(1, 4);
        step(4);
        req = 4'b0000;
        step(2);
        check("sat_idle_gnt", int'(gnt), 0);
`endif

        step(2);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
